// File: rtl/gb_cpu_common_pkg.sv
// Shared Game Boy CPU definitions: interrupt source numbering, interrupt
// controller state encoding and the ISR vector helper.
package gb_cpu_common_pkg;

  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  localparam logic [15:0] VECTOR_BASE = 16'h0040;

  typedef enum logic [2:0] {
    SRC_VBLANK = 3'd0,
    SRC_STAT   = 3'd1,
    SRC_TIMER  = 3'd2,
    SRC_SERIAL = 3'd3,
    SRC_JOYPAD = 3'd4
  } irq_source_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HALT = 2'd1,
    DISP = 2'd2
  } int_ctrl_state_t;

  // Each source owns an 8-byte slot above the base vector.
  function automatic logic [15:0] irq_vector(input logic [15:0] base, input logic [2:0] idx);
    return base + {10'd0, idx, 3'd0};
  endfunction

endpackage

// File: rtl/gb_cpu_irq_priority.sv
// Fixed-priority encoder for pending interrupts: the lowest set bit wins
// (VBLANK highest). Used for both boundary arbitration and the step-4
// re-arbitration of the dispatch sequence.
module gb_cpu_irq_priority #(
  parameter int NUM_IRQ = 5
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [2:0]         index
);

  // Scan from the lowest priority upward so the highest-priority hit is kept.
  always_comb begin
    valid = 1'b0;
    index = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        index = 3'(i);
      end
    end
  end

endmodule

// File: rtl/gb_cpu_interrupt_ctrl.sv
// Game Boy CPU interrupt controller: IF/IE registers, IME with EI delay,
// HALT state and the 5-M-cycle ISR dispatch sequence. Runs on the M clock.
// Optional feature: define GB_CPU_HALT_BUG_EN to model the HALT bug
// (HALT with IME=0 and an interrupt already pending does not halt and
// instead pulses halt_bug_o so the next fetch skips the PC increment).
module gb_cpu_interrupt_ctrl #(
  parameter int          NUM_IRQ      = 5,
  parameter int          DISPATCH_CYC = 5,
  parameter logic [15:0] VECTOR_BASE  = gb_cpu_common_pkg::VECTOR_BASE
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [7:0]         reg_wdata,
  input  logic               if_wr_en,
  input  logic               ie_wr_en,
  input  logic               instr_boundary,
  input  logic               ei_cmd,
  input  logic               di_cmd,
  input  logic               reti_cmd,
  input  logic               halt_cmd,
  output logic [7:0]         if_rdata,
  output logic [7:0]         ie_rdata,
  output logic               ime_o,
  output logic               halted_o,
  output logic               dispatch_active,
  output logic [2:0]         dispatch_m_cycle,
  output logic [15:0]        dispatch_vector,
  output logic               halt_bug_o
);

  import gb_cpu_common_pkg::*;

  int_ctrl_state_t    state;
  logic [NUM_IRQ-1:0] if_q;
  logic [NUM_IRQ-1:0] if_next;
  logic [7:0]         ie_q;
  logic               ime_q;
  logic               ime_next;
  logic               ei_delay_q;
  logic               ei_delay_next;
  logic [2:0]         step_q;
  logic [15:0]        vector_q;

  logic [NUM_IRQ-1:0] pending;
  logic               arb_valid;
  logic [2:0]         arb_index;
  logic [15:0]        arb_vector;
  logic               wake;
  logic               boundary;
  logic               take_irq;
  logic               step_arb;
  logic               step_last;
  logic               halt_bug_cond;

  assign pending = if_q & ie_q[NUM_IRQ-1:0];

  gb_cpu_irq_priority #(
    .NUM_IRQ (NUM_IRQ)
  ) u_priority (
    .req   (pending),
    .valid (arb_valid),
    .index (arb_index)
  );

  // No surviving request at re-arbitration yields a null vector.
  assign arb_vector = arb_valid ? irq_vector(VECTOR_BASE, arb_index) : 16'h0000;

  // Waking from HALT behaves as an instruction boundary.
  assign wake      = (state == HALT) && arb_valid;
  assign boundary  = ((state == IDLE) && instr_boundary) || wake;
  assign take_irq  = boundary && ime_q && arb_valid;
  assign step_arb  = (state == DISP) && (step_q == 3'(DISPATCH_CYC - 1));
  assign step_last = (state == DISP) && (step_q == 3'(DISPATCH_CYC));

  // IF next value: CPU write, then serviced-bit clear, then new requests win.
  always_comb begin
    if_next = if_wr_en ? reg_wdata[NUM_IRQ-1:0] : if_q;
    if (step_arb && arb_valid) begin
      if_next[arb_index] = 1'b0;
    end
    if_next = if_next | irq_i;
  end

  // IME next value: delayed EI, immediate RETI, DI dominant, dispatch clears.
  always_comb begin
    ime_next      = ime_q;
    ei_delay_next = ei_delay_q;
    if (boundary && ei_delay_q) begin
      ime_next      = 1'b1;
      ei_delay_next = 1'b0;
    end
    if (ei_cmd) begin
      ei_delay_next = 1'b1;
    end
    if (reti_cmd) begin
      ime_next = 1'b1;
    end
    if (di_cmd) begin
      ime_next      = 1'b0;
      ei_delay_next = 1'b0;
    end
    if (take_irq) begin
      ime_next = 1'b0;
    end
  end

  // Architectural registers IF, IE, IME and the EI delay flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_q       <= '0;
      ie_q       <= 8'h00;
      ime_q      <= 1'b0;
      ei_delay_q <= 1'b0;
    end else begin
      if_q       <= if_next;
      ime_q      <= ime_next;
      ei_delay_q <= ei_delay_next;
      if (ie_wr_en) begin
        ie_q <= reg_wdata;
      end
    end
  end

  // Controller FSM: idle, halted, or stepping through the ISR dispatch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      step_q   <= 3'd0;
      vector_q <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (take_irq) begin
            state  <= DISP;
            step_q <= 3'd1;
          end else if (halt_cmd && !halt_bug_cond) begin
            state <= HALT;
          end
        end
        HALT: begin
          if (take_irq) begin
            state  <= DISP;
            step_q <= 3'd1;
          end else if (wake) begin
            state <= IDLE;
          end
        end
        DISP: begin
          if (step_arb) begin
            vector_q <= arb_vector;
          end
          if (step_last) begin
            state  <= IDLE;
            step_q <= 3'd0;
          end else begin
            step_q <= step_q + 3'd1;
          end
        end
        default: begin
          state  <= IDLE;
          step_q <= 3'd0;
        end
      endcase
    end
  end

`ifdef GB_CPU_HALT_BUG_EN
  logic halt_bug_q;

  assign halt_bug_cond = halt_cmd && !ime_q && arb_valid;

  // One-cycle pulse when a HALT is swallowed by an already-pending interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      halt_bug_q <= 1'b0;
    end else begin
      halt_bug_q <= (state == IDLE) && halt_bug_cond && !take_irq;
    end
  end

  assign halt_bug_o = halt_bug_q;
`else
  assign halt_bug_cond = 1'b0;
  assign halt_bug_o    = 1'b0;
`endif

  assign if_rdata         = {{(8 - NUM_IRQ){1'b1}}, if_q};
  assign ie_rdata         = ie_q;
  assign ime_o            = ime_q;
  assign halted_o         = (state == HALT);
  assign dispatch_active  = (state == DISP);
  assign dispatch_m_cycle = step_q;
  // The re-arbitration result is visible throughout step 4 (so an IE write
  // during the PCH push is honoured) and held from the register in step 5.
  assign dispatch_vector  = step_arb ? arb_vector : vector_q;

endmodule

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
// Self-checking bench for gb_cpu_interrupt_ctrl: directed scenarios plus a
// randomized run compared against a behavioural model of the controller.
module tb_gb_cpu_interrupt_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  irq_i;
  logic [7:0]  reg_wdata;
  logic        if_wr_en, ie_wr_en, instr_boundary;
  logic        ei_cmd, di_cmd, reti_cmd, halt_cmd;
  logic [7:0]  if_rdata, ie_rdata;
  logic        ime_o, halted_o, dispatch_active, halt_bug_o;
  logic [2:0]  dispatch_m_cycle;
  logic [15:0] dispatch_vector;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic [4:0]  m_if;
  logic [7:0]  m_ie;
  logic        m_ime, m_eid, m_halted, m_bug;
  int          m_step;
  logic [15:0] m_vhold;

  gb_cpu_interrupt_ctrl dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .irq_i            (irq_i),
    .reg_wdata        (reg_wdata),
    .if_wr_en         (if_wr_en),
    .ie_wr_en         (ie_wr_en),
    .instr_boundary   (instr_boundary),
    .ei_cmd           (ei_cmd),
    .di_cmd           (di_cmd),
    .reti_cmd         (reti_cmd),
    .halt_cmd         (halt_cmd),
    .if_rdata         (if_rdata),
    .ie_rdata         (ie_rdata),
    .ime_o            (ime_o),
    .halted_o         (halted_o),
    .dispatch_active  (dispatch_active),
    .dispatch_m_cycle (dispatch_m_cycle),
    .dispatch_vector  (dispatch_vector),
    .halt_bug_o       (halt_bug_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic int lowest(input logic [4:0] p);
    for (int i = 0; i < 5; i++) if (p[i]) return i;
    return -1;
  endfunction

  function automatic logic [15:0] vec_of(input int src);
    if (src < 0) return 16'h0000;
    return 16'h0040 + 16'(8 * src);
  endfunction

  function automatic logic [15:0] exp_vector();
    if (m_step == 4) return vec_of(lowest(m_if & m_ie[4:0]));
    return m_vhold;
  endfunction

  task automatic set_idle();
    irq_i = 5'd0; reg_wdata = 8'd0; if_wr_en = 1'b0; ie_wr_en = 1'b0;
    instr_boundary = 1'b0; ei_cmd = 1'b0; di_cmd = 1'b0; reti_cmd = 1'b0; halt_cmd = 1'b0;
  endtask

  task automatic model_reset();
    m_if = 5'd0; m_ie = 8'd0; m_ime = 1'b0; m_eid = 1'b0; m_halted = 1'b0;
    m_bug = 1'b0; m_step = 0; m_vhold = 16'h0000;
  endtask

  // Advance one M-cycle, evolving the model from the inputs presented.
  task automatic tick();
    logic [4:0]  pend, n_if;
    logic [7:0]  n_ie;
    logic        n_ime, n_eid, n_halted, n_bug, bnd, take;
    logic [15:0] n_vhold;
    int          n_step, lo;
    pend = m_if & m_ie[4:0];
    lo   = lowest(pend);
    bnd  = (m_step == 0 && !m_halted && instr_boundary) || (m_halted && pend != 5'd0);
    take = bnd && m_ime && pend != 5'd0;
    n_if = if_wr_en ? reg_wdata[4:0] : m_if;
    if (m_step == 4 && lo >= 0) n_if[lo] = 1'b0;
    n_if = n_if | irq_i;
    n_ie = ie_wr_en ? reg_wdata : m_ie;
    n_ime = m_ime; n_eid = m_eid;
    if (bnd && m_eid) begin n_ime = 1'b1; n_eid = 1'b0; end
    if (ei_cmd) n_eid = 1'b1;
    if (reti_cmd) n_ime = 1'b1;
    if (di_cmd) begin n_ime = 1'b0; n_eid = 1'b0; end
    if (take) n_ime = 1'b0;
    n_step = m_step; n_halted = m_halted; n_bug = 1'b0; n_vhold = m_vhold;
    if (m_step > 0) begin
      if (m_step == 4) n_vhold = vec_of(lo);
      n_step = (m_step == 5) ? 0 : m_step + 1;
    end else if (take) begin
      n_step = 1; n_halted = 1'b0;
    end else if (m_halted) begin
      if (pend != 5'd0) n_halted = 1'b0;
    end else if (halt_cmd) begin
`ifdef GB_CPU_HALT_BUG_EN
      if (!m_ime && pend != 5'd0) n_bug = 1'b1;
      else n_halted = 1'b1;
`else
      n_halted = 1'b1;
`endif
    end
    @(posedge clk);
    #1;
    m_if = n_if; m_ie = n_ie; m_ime = n_ime; m_eid = n_eid;
    m_halted = n_halted; m_bug = n_bug; m_step = n_step; m_vhold = n_vhold;
  endtask

  task automatic apply_reset();
    set_idle();
    reset_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    reset_n = 1'b0;
    #1;
    checks++; if (if_rdata !== 8'hE0) begin failures++; $display("FAIL reset_if got=%h exp=e0", if_rdata); end
    checks++; if (ie_rdata !== 8'h00) begin failures++; $display("FAIL reset_ie got=%h exp=00", ie_rdata); end
    checks++; if ({ime_o, halted_o, dispatch_active, halt_bug_o} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {ime_o, halted_o, dispatch_active, halt_bug_o}); end
    checks++; if (dispatch_m_cycle !== 3'd0 || dispatch_vector !== 16'h0000) begin
      failures++; $display("FAIL reset_disp got=%0d/%h exp=0/0000", dispatch_m_cycle, dispatch_vector); end
    @(negedge clk);
    reset_n = 1'b1;
    // start a dispatch, then abort it with reset
    ie_wr_en = 1'b1; reg_wdata = 8'h01; tick(); set_idle();
    reti_cmd = 1'b1; irq_i = 5'h01; tick(); set_idle();
    instr_boundary = 1'b1; tick(); set_idle();
    tick();
    checks++; if (dispatch_m_cycle !== 3'd2) begin failures++; $display("FAIL abort_pre got=%0d exp=2", dispatch_m_cycle); end
    reset_n = 1'b0;
    #1;
    model_reset();
    checks++; if (dispatch_active !== 1'b0 || dispatch_m_cycle !== 3'd0 || if_rdata !== 8'hE0 || ie_rdata !== 8'h00) begin
      failures++; $display("FAIL abort_reset got=%b/%0d/%h/%h exp=0/0/e0/00", dispatch_active, dispatch_m_cycle, if_rdata, ie_rdata); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_dispatch();
    apply_reset();
    ie_wr_en = 1'b1; reg_wdata = 8'h1F; tick(); set_idle();
    reti_cmd = 1'b1; tick(); set_idle();
    irq_i = 5'b00110; tick(); set_idle();
    instr_boundary = 1'b1; tick(); set_idle();
    checks++; if (ime_o !== 1'b0) begin failures++; $display("FAIL disp_ime got=%b exp=0", ime_o); end
    for (int s = 1; s <= 5; s++) begin
      checks++; if (dispatch_active !== 1'b1 || dispatch_m_cycle !== 3'(s)) begin
        failures++; $display("FAIL disp_step got=%b/%0d exp=1/%0d", dispatch_active, dispatch_m_cycle, s); end
      if (s >= 4) begin
        checks++; if (dispatch_vector !== 16'h0048) begin failures++; $display("FAIL disp_vec step=%0d got=%h exp=0048", s, dispatch_vector); end
      end
      if (s == 5) begin
        checks++; if (if_rdata !== 8'hE4) begin failures++; $display("FAIL disp_ifclr got=%h exp=e4", if_rdata); end
      end
      tick();
    end
    checks++; if (dispatch_active !== 1'b0 || dispatch_m_cycle !== 3'd0 || ime_o !== 1'b0 || if_rdata !== 8'hE4) begin
      failures++; $display("FAIL disp_end got=%b/%0d/%b/%h exp=0/0/0/e4", dispatch_active, dispatch_m_cycle, ime_o, if_rdata); end
  endtask

  task automatic test_ei_delay();
    apply_reset();
    ie_wr_en = 1'b1; reg_wdata = 8'h01; irq_i = 5'h01; tick(); set_idle();
    ei_cmd = 1'b1; tick(); set_idle();
    instr_boundary = 1'b1; tick(); set_idle();
    checks++; if (dispatch_active !== 1'b0 || ime_o !== 1'b1) begin
      failures++; $display("FAIL ei_nop got=%b/%b exp=0/1", dispatch_active, ime_o); end
    instr_boundary = 1'b1; tick(); set_idle();
    checks++; if (dispatch_active !== 1'b1 || dispatch_m_cycle !== 3'd1 || ime_o !== 1'b0) begin
      failures++; $display("FAIL ei_next got=%b/%0d/%b exp=1/1/0", dispatch_active, dispatch_m_cycle, ime_o); end
    repeat (3) tick();
    checks++; if (dispatch_vector !== 16'h0040) begin failures++; $display("FAIL ei_vec got=%h exp=0040", dispatch_vector); end
    repeat (2) tick();
    checks++; if (if_rdata !== 8'hE0 || dispatch_active !== 1'b0) begin
      failures++; $display("FAIL ei_end got=%h/%b exp=e0/0", if_rdata, dispatch_active); end
  endtask

  task automatic test_ie_cancel();
    apply_reset();
    ie_wr_en = 1'b1; reg_wdata = 8'h04; tick(); set_idle();
    reti_cmd = 1'b1; irq_i = 5'h04; tick(); set_idle();
    instr_boundary = 1'b1; tick(); set_idle();
    tick(); tick();
    checks++; if (dispatch_m_cycle !== 3'd3) begin failures++; $display("FAIL cancel_step got=%0d exp=3", dispatch_m_cycle); end
    ie_wr_en = 1'b1; reg_wdata = 8'h00; tick(); set_idle();
    checks++; if (dispatch_vector !== 16'h0000 || ie_rdata !== 8'h00) begin
      failures++; $display("FAIL cancel_vec4 got=%h/%h exp=0000/00", dispatch_vector, ie_rdata); end
    tick();
    checks++; if (dispatch_vector !== 16'h0000 || if_rdata !== 8'hE4) begin
      failures++; $display("FAIL cancel_vec5 got=%h/%h exp=0000/e4", dispatch_vector, if_rdata); end
    tick();
    checks++; if (dispatch_active !== 1'b0 || if_rdata !== 8'hE4) begin
      failures++; $display("FAIL cancel_end got=%b/%h exp=0/e4", dispatch_active, if_rdata); end
  endtask

  task automatic test_halt_wake();
    apply_reset();
    ie_wr_en = 1'b1; reg_wdata = 8'h10; tick(); set_idle();
    halt_cmd = 1'b1; tick(); set_idle();
    checks++; if (halted_o !== 1'b1) begin failures++; $display("FAIL halt_enter got=%b exp=1", halted_o); end
    tick();
    checks++; if (halted_o !== 1'b1) begin failures++; $display("FAIL halt_hold got=%b exp=1", halted_o); end
    irq_i = 5'h10; tick(); set_idle();
    checks++; if (halted_o !== 1'b1 || if_rdata !== 8'hF0) begin
      failures++; $display("FAIL halt_irq got=%b/%h exp=1/f0", halted_o, if_rdata); end
    tick();
    checks++; if (halted_o !== 1'b0 || dispatch_active !== 1'b0 || if_rdata !== 8'hF0) begin
      failures++; $display("FAIL halt_wake got=%b/%b/%h exp=0/0/f0", halted_o, dispatch_active, if_rdata); end
  endtask

  task automatic test_precedence();
    apply_reset();
    irq_i = 5'h1D; tick(); set_idle();
    checks++; if (if_rdata !== 8'hFD) begin failures++; $display("FAIL prec_set got=%h exp=fd", if_rdata); end
    if_wr_en = 1'b1; reg_wdata = 8'h00; irq_i = 5'h02; tick(); set_idle();
    checks++; if (if_rdata !== 8'hE2) begin failures++; $display("FAIL prec_wr got=%h exp=e2", if_rdata); end
    ei_cmd = 1'b1; di_cmd = 1'b1; tick(); set_idle();
    instr_boundary = 1'b1; tick(); tick(); set_idle();
    checks++; if (ime_o !== 1'b0) begin failures++; $display("FAIL prec_eidi got=%b exp=0", ime_o); end
  endtask

  task automatic test_halt_bug();
    apply_reset();
    ie_wr_en = 1'b1; reg_wdata = 8'h01; irq_i = 5'h01; tick(); set_idle();
    halt_cmd = 1'b1; tick(); set_idle();
`ifdef GB_CPU_HALT_BUG_EN
    checks++; if (halted_o !== 1'b0 || halt_bug_o !== 1'b1) begin
      failures++; $display("FAIL hbug_pulse got=%b/%b exp=0/1", halted_o, halt_bug_o); end
    tick();
    checks++; if (halt_bug_o !== 1'b0) begin failures++; $display("FAIL hbug_end got=%b exp=0", halt_bug_o); end
`else
    checks++; if (halted_o !== 1'b1 || halt_bug_o !== 1'b0) begin
      failures++; $display("FAIL hbug_halt got=%b/%b exp=1/0", halted_o, halt_bug_o); end
    tick();
    checks++; if (halted_o !== 1'b0 || halt_bug_o !== 1'b0) begin
      failures++; $display("FAIL hbug_wake got=%b/%b exp=0/0", halted_o, halt_bug_o); end
`endif
  endtask

  task automatic test_random();
    logic quiet;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      quiet          = (m_step != 0) || m_halted;
      irq_i          = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      reg_wdata      = 8'($urandom);
      if_wr_en       = ($urandom_range(0, 15) == 0);
      ie_wr_en       = ($urandom_range(0, 7) == 0);
      instr_boundary = !quiet && ($urandom_range(0, 2) == 0);
      ei_cmd         = !quiet && ($urandom_range(0, 9) == 0);
      di_cmd         = !quiet && ($urandom_range(0, 11) == 0);
      reti_cmd       = !quiet && ($urandom_range(0, 7) == 0);
      halt_cmd       = !quiet && ($urandom_range(0, 14) == 0);
      tick();
      checks++; if (if_rdata !== {3'b111, m_if}) begin failures++; $display("FAIL rnd_if c=%0d got=%h exp=%h", c, if_rdata, {3'b111, m_if}); end
      checks++; if (ie_rdata !== m_ie) begin failures++; $display("FAIL rnd_ie c=%0d got=%h exp=%h", c, ie_rdata, m_ie); end
      checks++; if (ime_o !== m_ime) begin failures++; $display("FAIL rnd_ime c=%0d got=%b exp=%b", c, ime_o, m_ime); end
      checks++; if (halted_o !== m_halted) begin failures++; $display("FAIL rnd_halt c=%0d got=%b exp=%b", c, halted_o, m_halted); end
      checks++; if (dispatch_active !== (m_step != 0) || dispatch_m_cycle !== 3'(m_step)) begin
        failures++; $display("FAIL rnd_step c=%0d got=%b/%0d exp=%0d", c, dispatch_active, dispatch_m_cycle, m_step); end
      if (m_step >= 4) begin
        checks++; if (dispatch_vector !== exp_vector()) begin
          failures++; $display("FAIL rnd_vec c=%0d got=%h exp=%h", c, dispatch_vector, exp_vector()); end
      end
      checks++; if (halt_bug_o !== m_bug) begin failures++; $display("FAIL rnd_hbug c=%0d got=%b exp=%b", c, halt_bug_o, m_bug); end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    model_reset();
    test_reset();
    test_dispatch();
    test_ei_delay();
    test_ie_cancel();
    test_halt_wake();
    test_precedence();
    test_halt_bug();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
